// File: rtl/if_id_inst_buffer_if.sv
// if_id_inst_buffer_if: fetch-side push, decode-side pop and status signals of the IF/ID queue
interface if_id_inst_buffer_if #(
  parameter int ADDR_W = 3
);
  logic              flush;
  logic              push_valid_1, push_valid_2, push_ready;
  logic [31:0]       push_inst_1, push_pc_1, push_inst_2, push_pc_2;
  logic [1:0]        push_ic_1, push_ic_2;
  logic              id_ready, id_valid_1, id_valid_2;
  logic [31:0]       id_inst_1, id_pc_1, id_inst_2, id_pc_2;
  logic [1:0]        id_ic_1, id_ic_2;
  logic [ADDR_W:0]   count;
  logic              overflow_err;
  modport slave (
    input  flush, push_valid_1, push_inst_1, push_pc_1, push_ic_1,
           push_valid_2, push_inst_2, push_pc_2, push_ic_2, id_ready,
    output push_ready, id_valid_1, id_inst_1, id_pc_1, id_ic_1,
           id_valid_2, id_inst_2, id_pc_2, id_ic_2, count, overflow_err
  );
  modport master (
    output flush, push_valid_1, push_inst_1, push_pc_1, push_ic_1,
           push_valid_2, push_inst_2, push_pc_2, push_ic_2, id_ready,
    input  push_ready, id_valid_1, id_inst_1, id_pc_1, id_ic_1,
           id_valid_2, id_inst_2, id_pc_2, id_ic_2, count, overflow_err
  );
endinterface

// File: rtl/if_id_inst_buffer.sv
// if_id_inst_buffer: dual-slot circular instruction queue between IF and ID.
// Define IF_ID_BYPASS_EN to let pushes into an empty queue reach ID in the same cycle.
module if_id_inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic clk,
  input logic reset,
  if_id_inst_buffer_if.slave bus
);
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  ic;
  } entry_t;
  entry_t mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  entry_t            s1, s2, h1, h2, e1, e2;
  logic              any_push, wr_en, byp, v1, v2;
  logic [1:0]        n_push, n_pop;
  assign s1 = {bus.push_inst_1, bus.push_pc_1, bus.push_ic_1};
  assign s2 = {bus.push_inst_2, bus.push_pc_2, bus.push_ic_2};
  assign any_push = bus.push_valid_1 | bus.push_valid_2;
  assign n_push = {1'b0, bus.push_valid_1} + {1'b0, bus.push_valid_2};
  assign bus.push_ready = count_q <= (ADDR_W+1)'(DEPTH - 2);
`ifdef IF_ID_BYPASS_EN
  assign byp = count_q == '0 && !bus.flush && any_push;
`else
  assign byp = 1'b0;
`endif
  // Bypass presents the compacted push slots in place of the (empty) queue head
  always_comb begin
    v1 = byp ? 1'b1 : count_q != '0;
    v2 = byp ? bus.push_valid_1 & bus.push_valid_2 : count_q >= (ADDR_W+1)'(2);
    h1 = byp ? (bus.push_valid_1 ? s1 : s2) : mem_q[rd_ptr_q];
    h2 = byp ? s2 : mem_q[rd_ptr_q + ADDR_W'(1)];
    e1 = v1 ? h1 : '0;
    e2 = v2 ? h2 : '0;
  end
  assign {bus.id_inst_1, bus.id_pc_1, bus.id_ic_1} = e1;
  assign {bus.id_inst_2, bus.id_pc_2, bus.id_ic_2} = e2;
  assign bus.id_valid_1 = v1;
  assign bus.id_valid_2 = v2;
  assign bus.count = count_q;
  assign bus.overflow_err = ovf_q;
  // A bypassed pair consumed by ID is never written
  always_comb begin
    wr_en = any_push & bus.push_ready & ~bus.flush & ~(byp & bus.id_ready);
    n_pop = (bus.id_ready & ~byp) ? {1'b0, v1} + {1'b0, v2} : 2'd0;
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + (wr_en ? ADDR_W'(n_push) : '0);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + ADDR_W'(n_pop);
    count_d = bus.flush ? '0
            : count_q + (wr_en ? (ADDR_W+1)'(n_push) : '0) - (ADDR_W+1)'(n_pop);
    ovf_d = ovf_q | (any_push & ~bus.push_ready & ~bus.flush);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  always_ff @(posedge clk)
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.push_valid_1 ? s1 : s2;
      if (bus.push_valid_1 & bus.push_valid_2) mem_q[wr_ptr_q + ADDR_W'(1)] <= s2;
    end
endmodule
